// File: rtl/fifo_wr_gen.sv
// Write-side FIFO traffic generator: waits for empty, then writes a patterned burst. Optional chksum port via FIFO_WR_GEN_CHKSUM_EN.
// Latency: first strobe one cycle after en && fifo_empty_flag. Backpressure: full ends the burst, or holds and retries the word.
`timescale 1ns/1ps
module fifo_wr_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        pat_sel,
    input  logic              retry_on_full,
    input  logic [DATA_W-1:0] start_val,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty_flag,
    input  logic              fifo_full_flag,
    output logic              fifo_wr_flag,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              burst_done,
`ifdef FIFO_WR_GEN_CHKSUM_EN
    output logic [DATA_W-1:0] chksum,
`endif
    output logic [LEN_W-1:0]  wr_count
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [1:0] PAT_INC  = 2'd0;
    localparam logic [1:0] PAT_DEC  = 2'd1;
    localparam logic [1:0] PAT_WALK = 2'd3;

    state_t            state, state_d;
    logic [1:0]        pat_q, pat_d;
    logic              retry_q, retry_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              flag_d;
    logic [DATA_W-1:0] data_d;
    logic [LEN_W-1:0]  cnt_d;
    logic [LEN_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] next_word;
    logic              acc;
    logic              arm;

    assign acc     = fifo_wr_flag && !fifo_full_flag;
    assign arm     = en && fifo_empty_flag;
    assign cnt_inc = wr_count + LEN_W'(1);

    // A walking-one pattern with a zero seed would never show a bit.
    assign seed = (pat_sel == PAT_WALK && start_val == '0)
                ? {{(DATA_W-1){1'b0}}, 1'b1} : start_val;

    always_comb begin
        next_word = fifo_wr_data;
        case (pat_q)
            PAT_INC:  next_word = fifo_wr_data + DATA_W'(1);
            PAT_DEC:  next_word = fifo_wr_data - DATA_W'(1);
            PAT_WALK: next_word = {fifo_wr_data[DATA_W-2:0], fifo_wr_data[DATA_W-1]};
            default:  next_word = fifo_wr_data;
        endcase
    end

    always_comb begin
        state_d = state;
        flag_d  = fifo_wr_flag;
        data_d  = fifo_wr_data;
        cnt_d   = wr_count;
        pat_d   = pat_q;
        retry_d = retry_q;
        len_d   = len_q;
        case (state)
            IDLE: begin
                flag_d = 1'b0;
                if (arm) begin
                    pat_d   = pat_sel;
                    retry_d = retry_on_full;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    data_d  = seed;
                    flag_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!en) begin
                    flag_d  = 1'b0;
                    state_d = IDLE;
                end else if (acc && len_q != '0 && cnt_inc == len_q) begin
                    cnt_d   = cnt_inc;
                    flag_d  = 1'b0;
                    state_d = DONE;
                end else if (acc) begin
                    cnt_d  = cnt_inc;
                    data_d = next_word;
                end else if (fifo_full_flag && !retry_q) begin
                    flag_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                flag_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            fifo_wr_flag <= 1'b0;
            fifo_wr_data <= '0;
            busy         <= 1'b0;
            burst_done   <= 1'b0;
            wr_count     <= '0;
            pat_q        <= '0;
            retry_q      <= 1'b0;
            len_q        <= '0;
        end else begin
            state        <= state_d;
            fifo_wr_flag <= flag_d;
            fifo_wr_data <= data_d;
            busy         <= (state_d != IDLE);
            burst_done   <= (state_d == DONE);
            wr_count     <= cnt_d;
            pat_q        <= pat_d;
            retry_q      <= retry_d;
            len_q        <= len_d;
        end
    end

`ifdef FIFO_WR_GEN_CHKSUM_EN
    logic [DATA_W-1:0] chk_d;

    // Accumulates exactly the words that are counted, so aborted strobes are excluded.
    always_comb begin
        chk_d = chksum;
        if (state == IDLE && arm) begin
            chk_d = '0;
        end else if (state == WRITE && en && acc) begin
            chk_d = chksum ^ fifo_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chksum <= '0;
        end else begin
            chksum <= chk_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Bench for fifo_wr_gen: directed scenarios plus random traffic against a burst-level reference model.
`timescale 1ns/1ps
module tb_fifo_wr_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] pat_sel;
    logic       retry_on_full;
    logic [7:0] start_val;
    logic [7:0] burst_len;
    logic       fifo_empty_flag;
    logic       fifo_full_flag;
    logic       fifo_wr_flag;
    logic [7:0] fifo_wr_data;
    logic       busy;
    logic       burst_done;
    logic [7:0] wr_count;
`ifdef FIFO_WR_GEN_CHKSUM_EN
    logic [7:0] chksum;
`endif

    always #5 clk = ~clk;

    fifo_wr_gen #(.DATA_W(8), .LEN_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .pat_sel         (pat_sel),
        .retry_on_full   (retry_on_full),
        .start_val       (start_val),
        .burst_len       (burst_len),
        .fifo_empty_flag (fifo_empty_flag),
        .fifo_full_flag  (fifo_full_flag),
        .fifo_wr_flag    (fifo_wr_flag),
        .fifo_wr_data    (fifo_wr_data),
        .busy            (busy),
        .burst_done      (burst_done),
`ifdef FIFO_WR_GEN_CHKSUM_EN
        .chksum          (chksum),
`endif
        .wr_count        (wr_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 writing, 2 done pulse; word k derived in closed form.
    int         m_phase = 0;
    int         m_k     = 0;
    logic [7:0] m_cnt   = 0;
    logic [7:0] m_data  = 0;
    logic [7:0] m_seed  = 0;
    logic [7:0] m_len   = 0;
    logic [7:0] m_chk   = 0;
    logic [1:0] m_pat   = 0;
    logic       m_retry = 0;

    function automatic logic [7:0] word_at(input int k);
        logic [15:0] t;
        case (m_pat)
            2'd0:    return m_seed + 8'(k);
            2'd1:    return m_seed - 8'(k);
            2'd2:    return m_seed;
            default: begin
                t = {m_seed, m_seed} << (k % 8);
                return t[15:8];
            end
        endcase
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_cnt = 0; m_data = 0; m_seed = 0;
            m_len = 0; m_pat = 0; m_retry = 0; m_chk = 0;
        end else begin
            case (m_phase)
                0: if (en && fifo_empty_flag) begin
                    m_pat   = pat_sel;
                    m_retry = retry_on_full;
                    m_len   = burst_len;
                    m_seed  = (pat_sel == 2'd3 && start_val == 8'd0) ? 8'd1 : start_val;
                    m_k = 0; m_cnt = 0; m_chk = 0;
                    m_data  = m_seed;
                    m_phase = 1;
                end
                1: if (!en) begin
                    m_phase = 0;
                end else if (!fifo_full_flag) begin
                    m_chk = m_chk ^ m_data;
                    m_k++;
                    m_cnt++;
                    if (m_len != 0 && m_k == int'(m_len)) m_phase = 2;
                    else m_data = word_at(m_k);
                end else if (!m_retry) begin
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic compare();
        check("wr_flag",    fifo_wr_flag, m_phase == 1);
        check("wr_data",    fifo_wr_data, m_data);
        check("busy",       busy,         m_phase != 0);
        check("burst_done", burst_done,   m_phase == 2);
        check("wr_count",   wr_count,     m_cnt);
`ifdef FIFO_WR_GEN_CHKSUM_EN
        check("chksum",     chksum,       m_chk);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic arm(input logic [1:0] p, input logic [7:0] s, input logic [7:0] l, input logic r);
        en = 1'b1; fifo_empty_flag = 1'b1; fifo_full_flag = 1'b0;
        pat_sel = p; start_val = s; burst_len = l; retry_on_full = r;
        step();
        fifo_empty_flag = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pat_sel = 0; retry_on_full = 0; start_val = 0;
        burst_len = 0; fifo_empty_flag = 0; fifo_full_flag = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Basic increment burst of 4
        arm(2'd0, 8'h10, 8'd4, 1'b0);
        check("basic_first", fifo_wr_data, 8'h10);
        repeat (4) step();
        check("basic_done", burst_done, 1'b1);
        check("basic_cnt", wr_count, 8'd4);
        check("basic_last", fifo_wr_data, 8'h13);
        step();
        check("basic_idle", busy, 1'b0);

        // Stop on full while the 6th word is presented
        arm(2'd0, 8'h30, 8'd0, 1'b0);
        repeat (5) step();
        fifo_full_flag = 1'b1;
        step();
        check("sof_flag", fifo_wr_flag, 1'b0);
        check("sof_done", burst_done, 1'b1);
        check("sof_cnt", wr_count, 8'd5);
        fifo_full_flag = 1'b0;
        repeat (2) step();

        // Retry on full holding 0x22, then abort after the third accepted word
        arm(2'd0, 8'h20, 8'd0, 1'b1);
        repeat (2) step();
        fifo_full_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("retry_hold", fifo_wr_data, 8'h22);
        end
        fifo_full_flag = 1'b0;
        step();
        check("retry_next", fifo_wr_data, 8'h23);
        en = 1'b0;
        step();
        check("abort_flag", fifo_wr_flag, 1'b0);
        check("abort_done", burst_done, 1'b0);
        check("abort_cnt", wr_count, 8'd3);
        step();

        // Decrement wrap, walking-one wrap, constant
        arm(2'd1, 8'h01, 8'd3, 1'b0);
        step();
        check("dec_wrap0", fifo_wr_data, 8'h00);
        step();
        check("dec_wrap1", fifo_wr_data, 8'hFF);
        repeat (3) step();
        arm(2'd3, 8'h00, 8'd9, 1'b0);
        check("walk_seed", fifo_wr_data, 8'h01);
        repeat (8) step();
        check("walk_wrap", fifo_wr_data, 8'h01);
        repeat (3) step();
        arm(2'd2, 8'h5A, 8'd3, 1'b0);
        repeat (2) step();
        check("const", fifo_wr_data, 8'h5A);
        repeat (3) step();

        // Checksum over 0x01, 0x02, 0x04
        arm(2'd3, 8'h01, 8'd3, 1'b0);
        repeat (4) step();
`ifdef FIFO_WR_GEN_CHKSUM_EN
        check("chk_sum", chksum, 8'h07);
`endif
        step();

        // Reset mid-burst
        arm(2'd0, 8'h40, 8'd0, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check("rst_flag", fifo_wr_flag, 1'b0);
        check("rst_data", fifo_wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n           = ($urandom_range(0, 299) != 0);
            en              = ($urandom_range(0, 29) != 0);
            fifo_empty_flag = $urandom_range(0, 1) == 1;
            fifo_full_flag  = ($urandom_range(0, 4) == 0);
            pat_sel         = 2'($urandom_range(0, 3));
            retry_on_full   = $urandom_range(0, 1) == 1;
            start_val       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            burst_len       = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_gen.md
Name: fifo_wr_gen

Overview:
- Parametrised write-side traffic generator for FIFO cores under test.
- Waits for the FIFO to be empty, then writes a burst of patterned data words until the burst length is reached, the FIFO fills, or it is aborted.
- Supports selectable data patterns, stop-on-full or retry-on-full operation, and per-burst accepted-write counting.
- Drives the FIFO write port directly; sits beside the matching read-side checker in FIFO test benches and on-board demos.

Parameters:
- DATA_W, 8: width of fifo_wr_data and start_val.
- LEN_W, 8: width of burst_len and wr_count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  level enable; arms a burst, and deasserting it aborts one.
- pat_sel  in  2  pattern select, sampled at burst start: 0 increment, 1 decrement, 2 constant, 3 walking-one rotate-left.
- retry_on_full  in  1  sampled at burst start: 0 = end the burst on full, 1 = hold the word and retry.
- start_val  in  DATA_W  first data word / pattern seed, sampled at burst start.
- burst_len  in  LEN_W  number of words per burst, sampled at burst start; 0 = unlimited.
- fifo_empty_flag  in  1  FIFO empty status.
- fifo_full_flag  in  1  FIFO full status.
- fifo_wr_flag  out  1  registered write strobe.
- fifo_wr_data  out  DATA_W  registered write data.
- busy  out  1  high while the state is not IDLE.
- burst_done  out  1  one-cycle pulse when a burst completes or terminates on full.
- wr_count  out  LEN_W  accepted writes in the current or last burst.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE;
  - fifo_wr_flag, fifo_wr_data, busy, burst_done and wr_count all 0;
  - latched mode, pattern and length registers 0.
- Accepted write: acc = fifo_wr_flag && !fifo_full_flag, evaluated in the same cycle. Data advances and wr_count increments only on acc.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If en && fifo_empty_flag: latch pat_sel, retry_on_full, burst_len and start_val; clear wr_count.
  - Next cycle: state WRITE, fifo_wr_flag=1, fifo_wr_data=start_val. Latency is one cycle from the arming condition to the first strobe.
  - If pat_sel=3 and start_val=0, the seed is forced to 1.
- WRITE, checked in priority order:
  1. !en: fifo_wr_flag<=0, go to IDLE, no burst_done pulse, wr_count holds.
  2. acc and latched len≠0 and wr_count+1==len: wr_count+1, fifo_wr_flag<=0, go to DONE.
  3. acc: wr_count+1; data <= next pattern value; fifo_wr_flag stays 1.
  4. fifo_full_flag with retry=0: fifo_wr_flag<=0, go to DONE. The unaccepted word is not counted.
  5. fifo_full_flag with retry=1: hold fifo_wr_flag=1 and the current data until accepted, so no word is lost.
- DONE: burst_done=1 for exactly one cycle, then IDLE. A new burst needs en && fifo_empty_flag again, so back-to-back bursts are impossible without the FIFO draining.
- Pattern arithmetic is modulo 2^DATA_W:
  - increment: 0xFF→0x00;
  - decrement: 0x00→0xFF;
  - constant: start_val;
  - walking-one: rotate left, MSB→LSB.
- wr_count is modulo 2^LEN_W; it wraps in unlimited mode.
- busy = (state≠IDLE), registered.
- Changes to pat_sel, retry_on_full, burst_len or start_val mid-burst have no effect until the next burst.
- A synchronous reset mid-burst returns everything to reset values on that edge.

Optional Feature:
- Macro: FIFO_WR_GEN_CHKSUM_EN.
- Defined:
  - adds output port chksum (out, DATA_W): the running XOR of every accepted word in the burst;
  - cleared at burst start and held after the burst ends;
  - reset value 0.
- Undefined: no chksum port and no checksum logic. All other behaviour is identical.

Test Plan:
- Basic burst: en=1, empty=1, pat_sel=0, start_val=0x10, burst_len=4, full=0 → words 0x10..0x13 on 4 consecutive strobes; burst_done pulses once; wr_count=4; busy drops the cycle after DONE.
- Stop-on-full: retry=0, burst_len=0, full asserted while the 6th word is presented → 5 writes accepted; the next cycle has fifo_wr_flag=0 and burst_done=1; wr_count=5.
- Retry-on-full: retry=1, full high for 3 cycles during word 0x22 → 0x22 held with strobe high for those 3 cycles; after full drops, 0x22 is accepted once and the sequence continues at 0x23.
- Patterns: pat_sel=1 with start 0x01 gives 0x01, 0x00, 0xFF; pat_sel=3 with start 0x00 gives 0x01, 0x02, 0x04…0x80, 0x01; pat_sel=2 repeats start_val.
- Abort and reset: drop en after the 3rd word → strobe low the next cycle, no burst_done, wr_count=3. Assert rst_n=0 mid-burst → all outputs 0 at the next edge.
- With FIFO_WR_GEN_CHKSUM_EN, words 0x01, 0x02, 0x04 → chksum=0x07, held after DONE and cleared at the next burst start.
